// File: rtl/sram_apb_bridge_v2.sv
// APB3/APB4 slave bridging config/debug traffic onto a single-port sync SRAM.
// Programmable read latency, byte strobes, and bounds/alignment errors.
module sram_apb_bridge_v2 #(
  parameter int AW     = 16,
  parameter int DW     = 23,
  parameter int DEPTH  = 2**AW,
  parameter int RD_LAT = 1,
  localparam int NB    = (DW + 7) / 8
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [31:0]   PADDR,
  input  logic [31:0]   PWDATA,
  input  logic [3:0]    PSTRB,
  output logic [31:0]   PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic [NB-1:0] sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
  localparam logic [2:0]  LAT_INIT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic [NB-1:0] be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] prdata_q, prdata_d;

  logic          setup;
  logic [AW-1:0] idx;
  logic          bad_addr;
  logic          unused_bits;

  assign setup    = PSEL & ~PENABLE;
  assign idx      = PADDR[AW+1:2];
  assign bad_addr = (PADDR[1:0] != 2'b00) ||
                    (32'(idx) >= DEPTH_U);

  assign unused_bits = ^{PADDR, PWDATA, PSTRB};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    cs_d      = 1'b0;
    wr_d      = 1'b0;
    be_d      = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (bad_addr) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (PWRITE) begin
            pready_d = 1'b1;
            // an all-zero strobe completes without touching the SRAM
            if (|PSTRB[NB-1:0]) begin
              cs_d    = 1'b1;
              wr_d    = 1'b1;
              be_d    = PSTRB[NB-1:0];
              addr_d  = idx;
              wdata_d = PWDATA[DW-1:0];
            end
          end else begin
            cs_d    = 1'b1;
            addr_d  = idx;
            cnt_d   = LAT_INIT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // count reaches zero in the cycle the SRAM data is valid
        if (cnt_q == 3'd0) begin
          prdata_d = sram_rdata;
          pready_d = 1'b1;
          state_d  = RD_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PRDATA     = 32'(prdata_q);
  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign sram_cs    = cs_q;
  assign sram_wr    = wr_q;
  assign sram_be    = be_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
